// File: rtl/dct_quant_zigzag.sv
// JPEG luma quantizer with zigzag serializer for one 8x8 block of Q16.16 DCT coefficients.
// Reciprocal-multiply divide, round half up, saturate, and stream with valid/ready.
module dct_quant_zigzag #(
    parameter int DATA_WIDTH = 32,
    parameter int DATA_DEPTH = 8,
    parameter int COEF_BITS  = 12,
    parameter int OUT_WIDTH  = 16
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       in_valid,
    output logic                                       in_ready,
    input  logic [DATA_WIDTH*DATA_DEPTH*DATA_DEPTH-1:0] data_in_matrix,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic [OUT_WIDTH-1:0]                       out_coef,
    output logic [5:0]                                 out_index,
    output logic                                       out_last
);

    localparam int N  = DATA_DEPTH * DATA_DEPTH;
    localparam int PW = DATA_WIDTH + 18;

    localparam int ZZ [64] = '{
         0,  1,  8, 16,  9,  2,  3, 10,
        17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34,
        27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36,
        29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46,
        53, 60, 61, 54, 47, 55, 62, 63
    };

    localparam int QTAB [64] = '{
        16,  11,  10,  16,  24,  40,  51,  61,
        12,  12,  14,  19,  26,  58,  60,  55,
        14,  13,  16,  24,  40,  57,  69,  56,
        14,  17,  22,  29,  51,  87,  80,  62,
        18,  22,  37,  56,  68, 109, 103,  77,
        24,  35,  55,  64,  81, 104, 113,  92,
        49,  64,  78,  87, 103, 121, 120, 101,
        72,  92,  95,  98, 112, 100, 103,  99
    };

    localparam logic signed [PW-1:0] HALF =
        {{(PW-32){1'b0}}, 1'b1, 31'd0};
    localparam logic signed [PW-1:0] QMAX =
        PW'(2**(COEF_BITS-1) - 1);
    localparam logic signed [PW-1:0] QMIN =
        PW'(-(2**(COEF_BITS-1)));

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   block_q [N];
    logic [DATA_WIDTH-1:0]   block_d [N];
    logic [5:0]              idx_q, idx_d;
    logic                    valid_q, valid_d;
    logic                    last_q, last_d;
    logic [OUT_WIDTH-1:0]    coef_q, coef_d;

    logic [16:0]             recip [64];
    logic [5:0]              ld_idx;
    logic [5:0]              ld_pos;
    logic signed [DATA_WIDTH-1:0] ld_coef;
    logic signed [PW-1:0]    coef_x;
    logic signed [PW-1:0]    rec_x;
    logic signed [PW-1:0]    prod;
    logic signed [PW-1:0]    q_full;
    logic signed [COEF_BITS-1:0] q_sat;
    logic [OUT_WIDTH-1:0]    ld_out;

    // Reciprocals fold to constants; no divider is built.
    for (genvar g = 0; g < 64; g++) begin : g_recip
        assign recip[g] =
            17'((131072 + QTAB[g]) / (2 * QTAB[g]));
    end

    // In IDLE the first beat is taken straight from the input bus.
    always_comb begin
        ld_idx = (state_q == IDLE) ? 6'd0 : idx_q + 6'd1;
        ld_pos = 6'(ZZ[ld_idx]);
        if (state_q == IDLE) begin
            ld_coef = data_in_matrix[int'(ld_pos)*DATA_WIDTH +: DATA_WIDTH];
        end else begin
            ld_coef = block_q[ld_pos];
        end
        coef_x = PW'(ld_coef);
        rec_x  = PW'({1'b0, recip[ld_pos]});
        prod   = coef_x * rec_x;
        q_full = (prod + HALF) >>> 32;
        if (q_full > QMAX) begin
            q_sat = QMAX[COEF_BITS-1:0];
        end else if (q_full < QMIN) begin
            q_sat = QMIN[COEF_BITS-1:0];
        end else begin
            q_sat = q_full[COEF_BITS-1:0];
        end
        ld_out = OUT_WIDTH'(q_sat);
    end

    always_comb begin
        state_d  = state_q;
        block_d  = block_q;
        idx_d    = idx_q;
        valid_d  = valid_q;
        last_d   = last_q;
        coef_d   = coef_q;
        in_ready = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    for (int i = 0; i < N; i++) begin
                        block_d[i] = data_in_matrix[i*DATA_WIDTH +: DATA_WIDTH];
                    end
                    state_d = STREAM;
                    idx_d   = 6'd0;
                    valid_d = 1'b1;
                    last_d  = 1'b0;
                    coef_d  = ld_out;
                end
            end
            STREAM: begin
                if (valid_q && out_ready) begin
                    if (idx_q == 6'd63) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                    end else begin
                        idx_d  = ld_idx;
                        coef_d = ld_out;
                        last_d = (ld_idx == 6'd63);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            coef_q  <= '0;
            for (int i = 0; i < N; i++) begin
                block_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            coef_q  <= coef_d;
            for (int i = 0; i < N; i++) begin
                block_q[i] <= block_d[i];
            end
        end
    end

    assign out_valid = valid_q;
    assign out_coef  = coef_q;
    assign out_index = idx_q;
    assign out_last  = last_q;

endmodule

// File: tb/tb_dct_quant_zigzag.sv
// Randomized bench for dct_quant_zigzag against a plain-arithmetic quantizer
// and a diagonal-walk zigzag model.
module tb_dct_quant_zigzag;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [2047:0] data_in_matrix;
    logic          out_valid;
    logic          out_ready;
    logic [15:0]   out_coef;
    logic [5:0]    out_index;
    logic          out_last;

    dct_quant_zigzag dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .data_in_matrix (data_in_matrix),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_coef       (out_coef),
        .out_index      (out_index),
        .out_last       (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int errors  = 0;

    int QT [64] = '{
        16,  11,  10,  16,  24,  40,  51,  61,
        12,  12,  14,  19,  26,  58,  60,  55,
        14,  13,  16,  24,  40,  57,  69,  56,
        14,  17,  22,  29,  51,  87,  80,  62,
        18,  22,  37,  56,  68, 109, 103,  77,
        24,  35,  55,  64,  81, 104, 113,  92,
        49,  64,  78,  87, 103, 121, 120, 101,
        72,  92,  95,  98, 112, 100, 103,  99
    };

    longint exp_v [64];
    longint obs   [64];
    int     first_cyc;
    int     last_cyc;

    task automatic check(input string tag, input longint got, input longint want);
        vectors++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", tag, got, want);
        end
    endtask

    // Reference: divide by Q as a real reciprocal, round half up, clamp.
    task automatic build_model(input logic [2047:0] b);
        int zz [64];
        int k;
        int lo, hi;
        k = 0;
        for (int s = 0; s < 15; s++) begin
            lo = (s > 7) ? s - 7 : 0;
            hi = (s < 7) ? s : 7;
            if (s % 2 == 0) begin
                for (int r = hi; r >= lo; r--) begin
                    zz[k] = r * 8 + (s - r);
                    k++;
                end
            end else begin
                for (int r = lo; r <= hi; r++) begin
                    zz[k] = r * 8 + (s - r);
                    k++;
                end
            end
        end
        for (int i = 0; i < 64; i++) begin
            logic signed [31:0] raw;
            longint c, rc, v;
            raw = b[zz[i]*32 +: 32];
            c   = raw;
            rc  = $rtoi(65536.0 / QT[zz[i]] + 0.5);
            v   = (c * rc + (64'sd1 <<< 31)) >>> 32;
            if (v > 2047) v = 2047;
            if (v < -2048) v = -2048;
            exp_v[i] = v;
        end
    endtask

    function automatic logic [2047:0] rand_block(input int kind);
        logic [2047:0] b;
        b = '0;
        for (int i = 0; i < 64; i++) begin
            if (kind == 0) begin
                b[i*32 +: 32] = 32'($urandom_range(0, 1 << 24)) - 32'(1 << 23);
            end else begin
                b[i*32 +: 32] = $urandom;
            end
        end
        return b;
    endfunction

    // Streams one block; mode 1 randomizes out_ready. Ends at edge+1.
    task automatic run_block(input logic [2047:0] b, input bit rnd_ready,
                             input bit keep_valid, input int abort_at);
        int n = 0;
        int guard = 0;
        bit stalled = 0;
        logic [15:0] p_coef;
        logic [5:0]  p_idx;
        logic        p_last;
        build_model(b);
        data_in_matrix = b;
        in_valid = 1'b1;
        while (!in_ready && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready) check("accept_timeout", 0, 1);
        @(posedge clk); #1;
        check("in_ready_fall", in_ready, 0);
        if (keep_valid) data_in_matrix = rand_block(1);
        else in_valid = 1'b0;
        first_cyc = cyc;
        guard = 0;
        while (n < 64 && guard < 2000) begin
            if (n == abort_at) break;
            check("valid_hold", out_valid, 1);
            if (stalled) begin
                check("stall_coef", out_coef, p_coef);
                check("stall_idx", out_index, p_idx);
                check("stall_last", out_last, p_last);
            end
            out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid && out_ready) begin
                obs[n] = longint'($signed(out_coef));
                check($sformatf("idx%0d", n), out_index, n);
                check($sformatf("coef%0d", n), obs[n], exp_v[n]);
                check($sformatf("last%0d", n), out_last, n == 63);
                last_cyc = cyc;
                n++;
            end
            stalled = !out_ready;
            p_coef = out_coef;
            p_idx  = out_index;
            p_last = out_last;
            @(posedge clk); #1;
            guard++;
        end
        if (abort_at < 0) begin
            check("beat_count", n, 64);
            check("end_valid", out_valid, 0);
            check("end_ready", in_ready, 1);
        end
    endtask

    initial begin
        logic [2047:0] b, b2;
        int c1_end;
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        data_in_matrix = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", in_ready, 1);
        check("rst_valid", out_valid, 0);
        check("rst_coef", out_coef, 0);
        check("rst_index", out_index, 0);
        check("rst_last", out_last, 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        b = '0;
        b[31:0] = 32'h0010_0000;
        run_block(b, 0, 0, -1);
        check("t1_beat0", obs[0], 1);
        check("t1_beat5", obs[5], 0);

        b = '0;
        b[1*32 +: 32] = 32'hFFC9_0000;
        b[8*32 +: 32] = 32'h000C_0000;
        run_block(b, 0, 0, -1);
        check("t2_beat1", obs[1], -5);
        check("t2_beat2", obs[2], 1);
        check("t2_beat0", obs[0], 0);

        b = '0;
        b[31:0] = 32'h7FFF_0000;
        run_block(b, 0, 0, -1);
        check("sat_pos", obs[0], 2047);
        b[31:0] = 32'h8000_0000;
        run_block(b, 0, 0, -1);
        check("sat_neg", obs[0], -2048);

        for (int t = 0; t < 4; t++) begin
            run_block(rand_block(t % 2), 1, 1, -1);
            in_valid = 1'b0;
        end

        run_block(rand_block(0), 1, 0, 20);
        #2;
        reset = 1'b1;
        #1;
        check("abort_valid", out_valid, 0);
        check("abort_ready", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("post_abort_valid", out_valid, 0);
        run_block(rand_block(0), 0, 0, -1);

        b  = rand_block(0);
        b2 = rand_block(1);
        run_block(b, 0, 1, -1);
        c1_end = last_cyc;
        run_block(b2, 0, 1, -1);
        in_valid = 1'b0;
        check("b2b_gap", first_cyc - c1_end, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
